// File: rtl/pulse_period_meter_if.sv
// Pulse period meter bus: the pulse train going in and the measurement results coming out.
//   pulse_in      pulse train, may be asynchronous to clk (driven by master)
//   period        last measured period in clk cycles, held between strobes
//   period_valid  one-cycle strobe, period updated
//   locked        enough consecutive in-tolerance periods have been seen
//   timeout       no rising edge for the timeout window
interface pulse_period_meter_if #(
    parameter int unsigned CTR_BITS = 27
);
    logic                pulse_in;
    logic [CTR_BITS-1:0] period;
    logic                period_valid;
    logic                locked;
    logic                timeout;

    modport master (
        output pulse_in,
        input  period,
        input  period_valid,
        input  locked,
        input  timeout
    );

    modport slave (
        input  pulse_in,
        output period,
        output period_valid,
        output locked,
        output timeout
    );
endinterface

// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle spacing of rising edges on an asynchronous pulse
// train, strobes each period, and reports lock / timeout status.
//   clk    system clock
//   rst    synchronous active-high reset
//   pm_if  slave side of pulse_period_meter_if (pulse_in in, results out)
module pulse_period_meter #(
    parameter int unsigned DUR        = 50000000,
    parameter int unsigned TOL        = 1000,
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pulse_period_meter_if.slave   pm_if
);
    localparam int unsigned TIMEOUT  = 2 * DUR;
    localparam int unsigned CTR_BITS = $clog2(TIMEOUT + 1);
    localparam int unsigned DW       = CTR_BITS + 1;
    localparam int unsigned MC_BITS  = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TMO     = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                sync1_q, sync2_q, prev_q;
    logic [CTR_BITS-1:0] ctr_q, ctr_d;
    logic [CTR_BITS-1:0] period_q, period_d;
    logic                valid_q, valid_d;
    logic                locked_q, locked_d;
    logic                timeout_q, timeout_d;
    logic [MC_BITS-1:0]  match_cnt_q, match_cnt_d;

    logic                edge_c;
    logic [DW-1:0]       ctr_inc_c;
    logic signed [DW-1:0] diff_c;
    logic signed [DW-1:0] abs_c;
    logic                match_c;
    logic                thresh_c;

    // Synchronizer, edge detector and all state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            state_q     <= IDLE;
            ctr_q       <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            sync1_q     <= pm_if.pulse_in;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    // Period arithmetic; one extra bit keeps the signed difference from wrapping.
    always_comb begin
        edge_c    = sync2_q & ~prev_q;
        ctr_inc_c = {1'b0, ctr_q} + DW'(1);
        diff_c    = $signed(ctr_inc_c) - $signed(DW'(DUR));
        abs_c     = diff_c[DW-1] ? -diff_c : diff_c;
        match_c   = (abs_c <= $signed(DW'(TOL)));
        thresh_c  = (ctr_inc_c == DW'(TIMEOUT));
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;
        match_cnt_d = match_cnt_q;

        // Interval counter restarts on every edge and saturates at the timeout.
        if (edge_c) begin
            ctr_d = '0;
        end else if (ctr_q != CTR_BITS'(TIMEOUT)) begin
            ctr_d = ctr_q + CTR_BITS'(1);
        end else begin
            ctr_d = ctr_q;
        end

        case (state_q)
            IDLE: begin
                if (edge_c) begin
                    state_d = MEASURE;
                end else if (thresh_c) begin
                    state_d     = TMO;
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    match_cnt_d = '0;
                end
            end
            MEASURE: begin
                if (edge_c) begin
                    // ctr+1 never exceeds TIMEOUT here, so it fits CTR_BITS.
                    period_d = ctr_inc_c[CTR_BITS-1:0];
                    valid_d  = 1'b1;
                    if (!match_c) begin
                        match_cnt_d = '0;
                        locked_d    = 1'b0;
                    end else if (match_cnt_q >= MC_BITS'(LOCK_COUNT - 1)) begin
                        match_cnt_d = MC_BITS'(LOCK_COUNT);
                        locked_d    = 1'b1;
                    end else begin
                        match_cnt_d = match_cnt_q + MC_BITS'(1);
                        locked_d    = 1'b0;
                    end
                end else if (thresh_c) begin
                    state_d     = TMO;
                    timeout_d   = 1'b1;
                    locked_d    = 1'b0;
                    match_cnt_d = '0;
                end
            end
            TMO: begin
                // The interval ending here spans a gap, so it is not reported.
                if (edge_c) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign pm_if.period       = period_q;
    assign pm_if.period_valid = valid_q;
    assign pm_if.locked       = locked_q;
    assign pm_if.timeout      = timeout_q;
endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter with DUR=10, TOL=1, LOCK_COUNT=3.
module tb_pulse_period_meter;
    localparam int DUR     = 10;
    localparam int TOL     = 1;
    localparam int LC      = 3;
    localparam int TIMEOUT = 2 * DUR;
    localparam int CB      = $clog2(TIMEOUT + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pulse_period_meter_if #(.CTR_BITS(CB)) pm_if ();

    pulse_period_meter #(
        .DUR(DUR), .TOL(TOL), .LOCK_COUNT(LC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pm_if(pm_if)
    );

    // Observed outputs packed as {period, valid, locked, timeout}.
    wire [CB+2:0] obs_v = {pm_if.period, pm_if.period_valid, pm_if.locked, pm_if.timeout};

    int checks = 0;
    int errors = 0;

    // Reference model, expressed in terms of input sample times.
    int           p = 0;
    int           ref_s;
    bit           started, m_tmo, m_locked, prev_v;
    int           m_period, run;
    logic [CB+2:0] pipe [3];
    logic [CB+2:0] exp_v;

    // Drives one cycle, advances the model, and leaves exp_v for this cycle.
    task automatic step(input logic v, input logic r);
        bit e, vld;
        int diff;
        pm_if.pulse_in = v;
        rst = r;
        @(posedge clk);
        p++;
        if (r) begin
            // A reset behaves like an unreported edge two samples earlier.
            ref_s = p - 2; started = 0; m_tmo = 0; m_locked = 0;
            run = 0; m_period = 0; prev_v = 0;
            for (int i = 0; i < 3; i++) pipe[i] = '0;
        end else begin
            e = v & ~prev_v;
            prev_v = v;
            vld = 0;
            if (e) begin
                if (started && !m_tmo) begin
                    m_period = p - ref_s;
                    vld = 1;
                    diff = (m_period > DUR) ? m_period - DUR : DUR - m_period;
                    if (diff <= TOL) run = (run + 1 > LC) ? LC : run + 1;
                    else run = 0;
                    m_locked = (run == LC);
                end
                started = 1; m_tmo = 0; ref_s = p;
            end else if (!m_tmo && (p - ref_s == TIMEOUT)) begin
                m_tmo = 1; m_locked = 0; run = 0;
            end
            // An edge sampled now shows on the outputs two clocks later.
            pipe[(p + 2) % 3] = {CB'(m_period), vld, m_locked, m_tmo};
        end
        exp_v = pipe[p % 3];
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        checks++;
        if (obs_v !== '0) begin
            errors++; $display("FAIL reset_state got %h exp 0", obs_v);
        end
        checks++;
        if (obs_v !== exp_v) begin
            errors++; $display("FAIL reset_model got %h exp %h", obs_v, exp_v);
        end
    endtask

    task automatic test_lock();
        int gaps [5] = '{10, 10, 10, 10, 10};
        int strobes = 0;
        foreach (gaps[g]) begin
            for (int k = 0; k < gaps[g]; k++) begin
                step(k < 1, 1'b0);
                if (pm_if.period_valid) strobes++;
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL lock t=%0d got %h exp %h", p, obs_v, exp_v);
                end
            end
        end
        checks++;
        if (strobes !== 4 || pm_if.locked !== 1'b1 || pm_if.period !== CB'(10)) begin
            errors++;
            $display("FAIL lock_end strobes=%0d locked=%b period=%0d exp 4 1 10",
                     strobes, pm_if.locked, pm_if.period);
        end
    endtask

    task automatic test_mismatch();
        int gaps [5] = '{12, 10, 10, 10, 10};
        bit seen_unlock = 0;
        foreach (gaps[g]) begin
            for (int k = 0; k < gaps[g]; k++) begin
                step(k < 1, 1'b0);
                if (pm_if.period_valid && pm_if.period == CB'(12) && !pm_if.locked) seen_unlock = 1;
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL mismatch t=%0d got %h exp %h", p, obs_v, exp_v);
                end
            end
        end
        checks++;
        if (!seen_unlock || pm_if.locked !== 1'b1) begin
            errors++;
            $display("FAIL mismatch_end unlock_seen=%b locked=%b exp 1 1", seen_unlock, pm_if.locked);
        end
    endtask

    task automatic test_tolerance();
        int gaps [5] = '{13, 11, 9, 11, 10};
        foreach (gaps[g]) begin
            for (int k = 0; k < gaps[g]; k++) begin
                step(k < 1, 1'b0);
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL tolerance t=%0d got %h exp %h", p, obs_v, exp_v);
                end
            end
        end
        checks++;
        if (pm_if.locked !== 1'b1 || pm_if.period !== CB'(11)) begin
            errors++;
            $display("FAIL tolerance_end locked=%b period=%0d exp 1 11", pm_if.locked, pm_if.period);
        end
    endtask

    task automatic test_timeout();
        int gaps [3] = '{25, 10, 10};
        foreach (gaps[g]) begin
            for (int k = 0; k < gaps[g]; k++) begin
                step(k < 1, 1'b0);
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL timeout t=%0d got %h exp %h", p, obs_v, exp_v);
                end
            end
            if (g == 0) begin
                checks++;
                if (pm_if.timeout !== 1'b1 || pm_if.locked !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_set timeout=%b locked=%b exp 1 0", pm_if.timeout, pm_if.locked);
                end
            end
        end
        checks++;
        if (pm_if.timeout !== 1'b0 || pm_if.period !== CB'(10)) begin
            errors++;
            $display("FAIL timeout_recover timeout=%b period=%0d exp 0 10", pm_if.timeout, pm_if.period);
        end
    endtask

    task automatic test_reset_mid();
        int gaps [3] = '{10, 10, 10};
        int strobes = 0;
        for (int k = 0; k < 15; k++) begin
            step(k == 0 || k == 10, 1'b0);
            checks++;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL reset_mid_pre t=%0d got %h exp %h", p, obs_v, exp_v);
            end
        end
        step(1'b0, 1'b1);
        checks++;
        if (obs_v !== '0) begin
            errors++; $display("FAIL reset_mid_clear got %h exp 0", obs_v);
        end
        foreach (gaps[g]) begin
            for (int k = 0; k < gaps[g]; k++) begin
                step(k < 1, 1'b0);
                if (pm_if.period_valid) strobes++;
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL reset_mid t=%0d got %h exp %h", p, obs_v, exp_v);
                end
            end
        end
        checks++;
        if (strobes !== 2) begin
            errors++; $display("FAIL reset_mid_strobes got %0d exp 2", strobes);
        end
    endtask

    task automatic test_held_high();
        int gaps [2] = '{20, 20};
        int strobes = 0;
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        foreach (gaps[g]) begin
            for (int k = 0; k < gaps[g]; k++) begin
                step(k < 5, 1'b0);
                if (pm_if.period_valid) strobes++;
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL held_high t=%0d got %h exp %h", p, obs_v, exp_v);
                end
            end
        end
        checks++;
        if (strobes !== 1 || pm_if.period !== CB'(20) || pm_if.timeout !== 1'b0) begin
            errors++;
            $display("FAIL held_high_end strobes=%0d period=%0d timeout=%b exp 1 20 0",
                     strobes, pm_if.period, pm_if.timeout);
        end
    endtask

    task automatic test_random();
        int g, w, nr;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(14, 0) == 0) begin
                nr = $urandom_range(3, 1);
                for (int k = 0; k < nr; k++) step(1'($urandom_range(1, 0)), 1'b1);
            end
            g = $urandom_range(22, 2);
            w = $urandom_range((g - 1 > 5) ? 5 : g - 1, 1);
            for (int k = 0; k < g; k++) begin
                step(k < w, 1'b0);
                checks++;
                if (obs_v !== exp_v) begin
                    errors++; $display("FAIL random t=%0d got %h exp %h", p, obs_v, exp_v);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        pm_if.pulse_in = 1'b0;
        test_reset();
        test_lock();
        test_mismatch();
        test_tolerance();
        test_timeout();
        test_reset_mid();
        test_held_high();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
